// File: rtl/mlp_pkg.sv
// mlp_pkg: shared types and sizing for the MLP weight-memory path.
//   mlp_req_id_e : identifies a weight SRAM requester (none / init loader / compute).
//   WAddrWidth   : weight SRAM address width (2048 words = Layers x Neurons x Neurons).
//   WDataWidth   : weight word width.
package mlp_pkg;

    localparam int unsigned WAddrWidth = 11;
    localparam int unsigned WDataWidth = 16;
    localparam int unsigned Layers     = 8;
    localparam int unsigned Neurons    = 16;

    typedef enum logic [1:0] {
        ReqNone = 2'd0,
        ReqInit = 2'd1,
        ReqComp = 2'd2
    } mlp_req_id_e;

endpackage

// File: rtl/mlp_wmem_arb_if.sv
// mlp_wmem_arb_if: one requester's port onto the weight SRAM arbiter.
//   valid/ready   : request handshake (beat accepted when both high)
//   we            : 1 = write, 0 = read
//   addr/wdata    : request address and write data
//   rvalid/rdata  : read response, one cycle after an accepted read, no back-pressure
// Modports: master = requester side, slave = arbiter side.
interface mlp_wmem_arb_if import mlp_pkg::*; #(
    parameter int unsigned AddrWidth = WAddrWidth,
    parameter int unsigned DataWidth = WDataWidth
) ();

    logic                 valid;
    logic                 ready;
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic                 rvalid;
    logic [DataWidth-1:0] rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rvalid, rdata
    );

endinterface

// File: rtl/mlp_rr_pick.sv
// mlp_rr_pick: two-way round-robin grant with burst locking and a fairness cap.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_init_i   : init requester valid
//   req_comp_i   : compute requester valid
//   gnt_o        : combinational grant for this cycle (ReqNone while in reset)
// The current owner keeps the grant until it drops valid, or until it has taken
// MaxBurst consecutive beats while the other side is waiting.
module mlp_rr_pick import mlp_pkg::*; #(
    parameter int unsigned MaxBurst = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_init_i,
    input  logic        req_comp_i,
    output mlp_req_id_e gnt_o
);

    localparam int unsigned CntWidth = $clog2(MaxBurst + 1);

    mlp_req_id_e         owner_q, owner_d;
    mlp_req_id_e         last_q, last_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                cap_hit;

    assign cap_hit = (cnt_q == CntWidth'(MaxBurst));

    always_comb begin
        gnt_o   = ReqNone;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        if (rst_i) begin
            gnt_o = ReqNone;
        end else if (owner_q == ReqInit && req_init_i && !(cap_hit && req_comp_i)) begin
            gnt_o = ReqInit;
        end else if (owner_q == ReqComp && req_comp_i && !(cap_hit && req_init_i)) begin
            gnt_o = ReqComp;
        end else if (req_init_i && !req_comp_i) begin
            gnt_o = ReqInit;
        end else if (!req_init_i && req_comp_i) begin
            gnt_o = ReqComp;
        end else if (req_init_i && req_comp_i) begin
            // A capped owner lands here too; last == owner, so the waiter wins.
            gnt_o = (last_q == ReqInit) ? ReqComp : ReqInit;
        end

        if (gnt_o == ReqNone) begin
            owner_d = ReqNone;
            cnt_d   = '0;
        end else if (gnt_o == owner_q) begin
            // Saturate so an uncontended burst can run forever.
            if (!cap_hit) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            owner_d = gnt_o;
            cnt_d   = CntWidth'(1);
            last_d  = gnt_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q <= ReqNone;
            last_q  <= ReqInit;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/mlp_wmem_arb.sv
// mlp_wmem_arb: shares the single-port MLP weight SRAM between the host init
// loader and the MLP compute sequencer.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   init_if         : init loader request/response port (slave modport)
//   comp_if         : compute sequencer request/response port (slave modport)
//   mem_en_o/we_o/addr_o/wdata_o : SRAM command, driven combinationally from the grant
//   mem_rdata_i     : SRAM read data, valid one cycle after a read enable
//   stat_conflict_o : cycles where some requester was valid but not ready
// Build option: define MLP_WMEM_ARB_STATS_EN to build the saturating conflict
// counter; otherwise stat_conflict_o is tied to 0.
module mlp_wmem_arb import mlp_pkg::*; #(
    parameter int unsigned AddrWidth = WAddrWidth,
    parameter int unsigned DataWidth = WDataWidth,
    parameter int unsigned MaxBurst  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mlp_wmem_arb_if.slave        init_if,
    mlp_wmem_arb_if.slave        comp_if,
    output logic                 mem_en_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic [15:0]          stat_conflict_o
);

    mlp_req_id_e gnt;
    mlp_req_id_e rsp_id_q, rsp_id_d;
    logic        rsp_pend_q, rsp_pend_d;

    mlp_rr_pick #(
        .MaxBurst (MaxBurst)
    ) u_rr_pick (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_init_i (init_if.valid),
        .req_comp_i (comp_if.valid),
        .gnt_o      (gnt)
    );

    assign init_if.ready = (gnt == ReqInit);
    assign comp_if.ready = (gnt == ReqComp);

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (gnt)
            ReqInit: begin
                mem_en_o    = 1'b1;
                mem_we_o    = init_if.we;
                mem_addr_o  = init_if.addr;
                mem_wdata_o = init_if.wdata;
            end
            ReqComp: begin
                mem_en_o    = 1'b1;
                mem_we_o    = comp_if.we;
                mem_addr_o  = comp_if.addr;
                mem_wdata_o = comp_if.wdata;
            end
            default: ;
        endcase
    end

    // Remember who issued a read so the next-cycle data goes back to them.
    always_comb begin
        rsp_pend_d = mem_en_o && !mem_we_o;
        rsp_id_d   = gnt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_pend_q <= 1'b0;
            rsp_id_q   <= ReqNone;
        end else begin
            rsp_pend_q <= rsp_pend_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    // Gated by rst_i so a response due in the reset cycle is never presented.
    assign init_if.rvalid = !rst_i && rsp_pend_q && (rsp_id_q == ReqInit);
    assign comp_if.rvalid = !rst_i && rsp_pend_q && (rsp_id_q == ReqComp);
    assign init_if.rdata  = init_if.rvalid ? mem_rdata_i : '0;
    assign comp_if.rdata  = comp_if.rvalid ? mem_rdata_i : '0;

`ifdef MLP_WMEM_ARB_STATS_EN
    logic [15:0] stat_q, stat_d;
    logic        conflict;

    always_comb begin
        conflict = (init_if.valid && !init_if.ready) || (comp_if.valid && !comp_if.ready);
        stat_d   = stat_q;
        if (conflict && (stat_q != 16'hFFFF)) begin
            stat_d = stat_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_conflict_o = stat_q;
`else
    assign stat_conflict_o = '0;
`endif

endmodule

// File: tb/tb_mlp_wmem_arb.sv
// tb_mlp_wmem_arb: directed self-checking bench for mlp_wmem_arb (MaxBurst = 16)
// with a behavioural single-port SRAM (registered read) hung off the mem port.
module tb_mlp_wmem_arb;

`ifdef MLP_WMEM_ARB_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en, mem_we;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [15:0] stat_conflict;
    logic [15:0] sram [2048];

    int n_checks = 0;
    int n_errors = 0;

    mlp_wmem_arb_if init_if ();
    mlp_wmem_arb_if comp_if ();

    mlp_wmem_arb #(
        .AddrWidth (11),
        .DataWidth (16),
        .MaxBurst  (16)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .init_if         (init_if),
        .comp_if         (comp_if),
        .mem_en_o        (mem_en),
        .mem_we_o        (mem_we),
        .mem_addr_o      (mem_addr),
        .mem_wdata_o     (mem_wdata),
        .mem_rdata_i     (mem_rdata),
        .stat_conflict_o (stat_conflict)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_init(input logic v, input logic w, input logic [10:0] a,
                            input logic [15:0] d);
        init_if.valid = v;
        init_if.we    = w;
        init_if.addr  = a;
        init_if.wdata = d;
    endtask

    task automatic set_comp(input logic v, input logic w, input logic [10:0] a,
                            input logic [15:0] d);
        comp_if.valid = v;
        comp_if.we    = w;
        comp_if.addr  = a;
        comp_if.wdata = d;
    endtask

    initial begin
        logic exp_comp, prev_comp, prev_init;

        // Reset with both requesting: everything must stay quiet.
        rst = 1'b1;
        set_init(1'b1, 1'b1, 11'h001, 16'h1111);
        set_comp(1'b1, 1'b0, 11'h002, 16'h0000);
        tick();
        #4;
        chk("rst_init_ready", 32'(init_if.ready), 32'd0);
        chk("rst_comp_ready", 32'(comp_if.ready), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_init_rvalid", 32'(init_if.rvalid), 32'd0);
        chk("rst_comp_rvalid", 32'(comp_if.rvalid), 32'd0);
        chk("rst_stat", 32'(stat_conflict), 32'd0);
        tick();
        rst = 1'b0;
        set_comp(1'b0, 1'b0, 11'h000, 16'h0000);

        // Init-only write burst over the whole memory, valid held high.
        for (int i = 0; i < 2048; i++) begin
            set_init(1'b1, 1'b1, 11'(i), 16'(i) ^ 16'hA5A5);
            #4;
            chk("burst_init_ready", 32'(init_if.ready), 32'd1);
            chk("burst_comp_ready", 32'(comp_if.ready), 32'd0);
            chk("burst_mem_we", 32'(mem_we), 32'd1);
            chk("burst_mem_addr", 32'(mem_addr), 32'(i));
            tick();
        end
        set_init(1'b0, 1'b0, 11'h000, 16'h0000);
        #4;
        chk("burst_stat", 32'(stat_conflict), 32'd0);
        chk("idle_mem_en", 32'(mem_en), 32'd0);
        chk("idle_mem_addr", 32'(mem_addr), 32'd0);
        tick();

        // Comp back-to-back reads at 0x010..0x012.
        set_comp(1'b1, 1'b0, 11'h010, 16'h0000);
        #4;
        chk("rd0_comp_ready", 32'(comp_if.ready), 32'd1);
        chk("rd0_comp_rvalid", 32'(comp_if.rvalid), 32'd0);
        tick();
        set_comp(1'b1, 1'b0, 11'h011, 16'h0000);
        #4;
        chk("rd1_comp_ready", 32'(comp_if.ready), 32'd1);
        chk("rd1_comp_rvalid", 32'(comp_if.rvalid), 32'd1);
        chk("rd1_comp_rdata", 32'(comp_if.rdata), 32'h10 ^ 32'hA5A5);
        chk("rd1_init_rvalid", 32'(init_if.rvalid), 32'd0);
        tick();
        set_comp(1'b1, 1'b0, 11'h012, 16'h0000);
        #4;
        chk("rd2_comp_rvalid", 32'(comp_if.rvalid), 32'd1);
        chk("rd2_comp_rdata", 32'(comp_if.rdata), 32'h11 ^ 32'hA5A5);
        chk("rd2_init_rdata", 32'(init_if.rdata), 32'd0);
        tick();
        set_comp(1'b0, 1'b0, 11'h000, 16'h0000);
        #4;
        chk("rd3_comp_rvalid", 32'(comp_if.rvalid), 32'd1);
        chk("rd3_comp_rdata", 32'(comp_if.rdata), 32'h12 ^ 32'hA5A5);
        chk("rd3_init_rvalid", 32'(init_if.rvalid), 32'd0);
        tick();
        #4;
        chk("rd4_comp_rvalid", 32'(comp_if.rvalid), 32'd0);
        tick();

        // Both valid from reset: Comp 16, Init 16, Comp, with no idle gap.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_init(1'b1, 1'b0, 11'h100, 16'h0000);
        set_comp(1'b1, 1'b0, 11'h200, 16'h0000);
        prev_comp = 1'b0;
        prev_init = 1'b0;
        for (int b = 0; b < 33; b++) begin
            exp_comp = (b < 16) || (b == 32);
            #4;
            chk("rr_comp_ready", 32'(comp_if.ready), 32'(exp_comp));
            chk("rr_init_ready", 32'(init_if.ready), 32'(!exp_comp));
            chk("rr_mem_addr", 32'(mem_addr), exp_comp ? 32'h200 : 32'h100);
            chk("rr_comp_rvalid", 32'(comp_if.rvalid), 32'(prev_comp));
            chk("rr_init_rvalid", 32'(init_if.rvalid), 32'(prev_init));
            if (b == 16) begin
                chk("rr_stat_at_switch", 32'(stat_conflict), StatsEn ? 32'd16 : 32'd0);
            end
            prev_comp = exp_comp;
            prev_init = !exp_comp;
            tick();
        end
        set_init(1'b0, 1'b0, 11'h000, 16'h0000);
        set_comp(1'b0, 1'b0, 11'h000, 16'h0000);
        tick();

        // Uncontended Init burst past the cap, then Comp arrives: Comp wins at once.
        for (int i = 0; i < 20; i++) begin
            set_init(1'b1, 1'b1, 11'h300 + 11'(i), 16'h5A5A);
            #4;
            chk("long_init_ready", 32'(init_if.ready), 32'd1);
            tick();
        end
        set_comp(1'b1, 1'b0, 11'h020, 16'h0000);
        #4;
        chk("cap_comp_ready", 32'(comp_if.ready), 32'd1);
        chk("cap_init_ready", 32'(init_if.ready), 32'd0);
        tick();
        set_init(1'b0, 1'b0, 11'h000, 16'h0000);
        set_comp(1'b0, 1'b0, 11'h000, 16'h0000);
        tick();

        // Tie right after an Init burst goes to Comp; the following tie to Init.
        for (int i = 0; i < 3; i++) begin
            set_init(1'b1, 1'b1, 11'h340 + 11'(i), 16'h0F0F);
            tick();
        end
        set_init(1'b0, 1'b0, 11'h000, 16'h0000);
        tick();
        set_init(1'b1, 1'b0, 11'h030, 16'h0000);
        set_comp(1'b1, 1'b0, 11'h031, 16'h0000);
        #4;
        chk("tie1_comp_ready", 32'(comp_if.ready), 32'd1);
        chk("tie1_init_ready", 32'(init_if.ready), 32'd0);
        tick();
        set_init(1'b0, 1'b0, 11'h000, 16'h0000);
        set_comp(1'b0, 1'b0, 11'h000, 16'h0000);
        tick();
        set_init(1'b1, 1'b0, 11'h030, 16'h0000);
        set_comp(1'b1, 1'b0, 11'h031, 16'h0000);
        #4;
        chk("tie2_init_ready", 32'(init_if.ready), 32'd1);
        chk("tie2_comp_ready", 32'(comp_if.ready), 32'd0);
        chk("tie2_mem_addr", 32'(mem_addr), 32'h030);
        tick();
        set_init(1'b0, 1'b0, 11'h000, 16'h0000);
        set_comp(1'b0, 1'b0, 11'h000, 16'h0000);
        tick();

        // Reset the cycle after an accepted comp read: response is dropped.
        set_comp(1'b1, 1'b0, 11'h040, 16'h0000);
        #4;
        chk("rstrd_comp_ready", 32'(comp_if.ready), 32'd1);
        tick();
        set_comp(1'b0, 1'b0, 11'h000, 16'h0000);
        rst = 1'b1;
        #4;
        chk("rstrd_rvalid_in_rst", 32'(comp_if.rvalid), 32'd0);
        tick();
        rst = 1'b0;
        set_init(1'b1, 1'b1, 11'h7FF, 16'hBEEF);
        #4;
        chk("rstrd_rvalid_after", 32'(comp_if.rvalid), 32'd0);
        chk("rstrd_init_ready", 32'(init_if.ready), 32'd1);
        chk("rstrd_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        tick();
        set_init(1'b0, 1'b0, 11'h000, 16'h0000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
